// File: rtl/paddle_ctrl.sv
// paddle_ctrl: Pong paddle with joystick/auto tracking, accelerating movement, limit clamping and a registered pixel output
module paddle_ctrl #(
  parameter logic [2:0] COLOR       = 3'b111,
  parameter int         START_X     = 5,
  parameter int         START_Y     = 100,
  parameter int         WIDTH       = 4,
  parameter int         HEIGHT      = 40,
  parameter int         LIMIT_Y_MIN = 5,
  parameter int         LIMIT_Y_MAX = 475,
  parameter int         DIV_START   = 8,
  parameter int         DIV_MIN     = 2,
  parameter int         ACCEL_STEPS = 4,
  parameter int         DEADBAND    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_mode,
  input  logic       i_control_up,
  input  logic       i_control_down,
  input  logic [9:0] i_ball_y,
  input  logic [9:0] i_row,
  input  logic [9:0] i_col,
  output logic [2:0] o_rgb,
  output logic [9:0] o_pos_x,
  output logic [9:0] o_pos_y,
  output logic [7:0] o_size_x,
  output logic [7:0] o_size_y,
  output logic [7:0] o_speed,
  output logic       o_moving
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;
  state_t      r_state;
  logic [9:0]  r_pos_y;
  logic [7:0]  r_speed;
  logic [7:0]  r_timer;
  logic [7:0]  r_step_cnt;
  logic        r_moving;
  logic [2:0]  r_rgb;
  logic [10:0] w_pos_y;
  logic [10:0] w_ball_y;
  logic [10:0] w_centre;
  logic [10:0] w_row;
  logic [10:0] w_col;
  logic        w_auto_up;
  logic        w_auto_dn;
  logic        w_req_up;
  logic        w_req_dn;
  logic        w_dir_up;
  logic        w_hold;
  logic        w_tick;
  logic        w_can_step;
  logic        w_last_step;
  logic        w_inside;
  // Widen everything to 11 bits so pos_y+HEIGHT and ball_y+DEADBAND never wrap
  assign w_pos_y     = {1'b0, r_pos_y};
  assign w_ball_y    = {1'b0, i_ball_y};
  assign w_row       = {1'b0, i_row};
  assign w_col       = {1'b0, i_col};
  assign w_centre    = w_pos_y + 11'(HEIGHT / 2);
  assign w_auto_up   = (w_ball_y + 11'(DEADBAND)) < w_centre;
  assign w_auto_dn   = w_ball_y > (w_centre + 11'(DEADBAND));
  assign w_req_up    = i_mode ? w_auto_up : (!i_control_up && i_control_down);
  assign w_req_dn    = i_mode ? w_auto_dn : (!i_control_down && i_control_up);
  assign w_dir_up    = (r_state == MOVE_UP);
  assign w_hold      = i_enable && (w_dir_up ? w_req_up : w_req_dn);
  assign w_tick      = (r_timer == r_speed - 8'd1);
  assign w_can_step  = w_dir_up ? (r_pos_y > 10'(LIMIT_Y_MIN))
                                : ((w_pos_y + 11'(HEIGHT)) < 11'(LIMIT_Y_MAX));
  assign w_last_step = (r_step_cnt == 8'(ACCEL_STEPS - 1));
  assign w_inside    = (w_col >= 11'(START_X)) && (w_col < 11'(START_X + WIDTH)) &&
                       (w_row >= w_pos_y) && (w_row < w_pos_y + 11'(HEIGHT));
  // Movement FSM: idle until a request, then step every speed clocks, accelerating after each run of ACCEL_STEPS steps
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_pos_y    <= 10'(START_Y);
      r_speed    <= 8'(DIV_START);
      r_timer    <= 8'd0;
      r_step_cnt <= 8'd0;
      r_moving   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_timer    <= 8'd0;
      r_step_cnt <= 8'd0;
      r_speed    <= 8'(DIV_START);
      if (i_enable && w_req_up) begin
        r_state  <= MOVE_UP;
        r_moving <= 1'b1;
      end else if (i_enable && w_req_dn) begin
        r_state  <= MOVE_DOWN;
        r_moving <= 1'b1;
      end
    end else if (!w_hold) begin
      r_state    <= IDLE;
      r_moving   <= 1'b0;
      r_timer    <= 8'd0;
      r_step_cnt <= 8'd0;
      r_speed    <= 8'(DIV_START);
    end else if (w_tick) begin
      r_timer <= 8'd0;
      if (w_can_step) begin
        r_pos_y    <= w_dir_up ? r_pos_y - 10'd1 : r_pos_y + 10'd1;
        r_step_cnt <= w_last_step ? 8'd0 : r_step_cnt + 8'd1;
        if (w_last_step && r_speed > 8'(DIV_MIN))
          r_speed <= r_speed - 8'd1;
      end
    end else begin
      r_timer <= r_timer + 8'd1;
    end
  end
  // Pixel colour for the queried row/col against the paddle rectangle at this edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rgb <= 3'd0;
    else          r_rgb <= w_inside ? COLOR : 3'd0;
  end
  assign o_rgb    = r_rgb;
  assign o_pos_x  = 10'(START_X);
  assign o_pos_y  = r_pos_y;
  assign o_size_x = 8'(WIDTH);
  assign o_size_y = 8'(HEIGHT);
  assign o_speed  = r_speed;
  assign o_moving = r_moving;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed stimulus with a behavioural paddle model checked every cycle
module tb_paddle_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst_n, i_enable, i_mode, i_control_up, i_control_down;
  logic [9:0] i_ball_y, i_row, i_col;
  logic [2:0] o_rgb;
  logic [9:0] o_pos_x, o_pos_y;
  logic [7:0] o_size_x, o_size_y, o_speed;
  logic       o_moving;
  int tests = 0;
  int fails = 0;
  bit chk_on = 0;
  int m_pos, m_dir, m_el, m_div, m_run, m_rgb;

  paddle_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_mode(i_mode),
    .i_control_up(i_control_up), .i_control_down(i_control_down),
    .i_ball_y(i_ball_y), .i_row(i_row), .i_col(i_col),
    .o_rgb(o_rgb), .o_pos_x(o_pos_x), .o_pos_y(o_pos_y), .o_size_x(o_size_x),
    .o_size_y(o_size_y), .o_speed(o_speed), .o_moving(o_moving)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Model: dir 0=none 1=up 2=down; a step lands every m_div clocks of continuous hold
  initial forever begin
    int req, old;
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_pos = 100; m_dir = 0; m_el = 0; m_div = 8; m_run = 0; m_rgb = 0;
    end else begin
      old = m_pos;
      if (i_mode)
        req = (int'(i_ball_y) + 4 < m_pos + 20) ? 1 : (int'(i_ball_y) > m_pos + 24) ? 2 : 0;
      else
        req = (!i_control_up && i_control_down) ? 1 : (!i_control_down && i_control_up) ? 2 : 0;
      if (m_dir == 0) begin
        if (i_enable && req != 0) begin
          m_dir = req; m_el = 0; m_div = 8; m_run = 0;
        end
      end else if (!i_enable || req != m_dir) begin
        m_dir = 0; m_div = 8;
      end else begin
        m_el++;
        if (m_el == m_div) begin
          m_el = 0;
          if (m_dir == 1 ? (m_pos > 5) : (m_pos + 40 < 475)) begin
            m_pos += (m_dir == 1) ? -1 : 1;
            m_run++;
            if (m_run == 4) begin
              m_run = 0;
              if (m_div > 2) m_div--;
            end
          end
        end
      end
      m_rgb = (int'(i_col) >= 5 && int'(i_col) < 9 && int'(i_row) >= old && int'(i_row) < old + 40) ? 7 : 0;
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (chk_on) begin
      chk("pos_y", o_pos_y, m_pos);
      chk("speed", o_speed, m_div);
      chk("moving", o_moving, m_dir != 0);
      chk("rgb", o_rgb, m_rgb);
      chk("pos_x", o_pos_x, 5);
      chk("size_x", o_size_x, 4);
      chk("size_y", o_size_y, 40);
    end
  end

  initial begin
    i_rst_n = 0; i_enable = 1; i_mode = 0; i_control_up = 1; i_control_down = 1;
    i_ball_y = 0; i_row = 0; i_col = 0;
    tick(2);
    i_rst_n = 1; chk_on = 1;
    chk("rst_pos", o_pos_y, 100); chk("rst_speed", o_speed, 8);
    chk("rst_moving", o_moving, 0); chk("rst_rgb", o_rgb, 0);
    // hold up: first step 8 clocks after entry, then accelerate down to divider 2
    i_control_up = 0;
    tick(1); chk("up_enter", o_moving, 1); chk("up_enter_pos", o_pos_y, 100);
    tick(7); chk("before_first", o_pos_y, 100);
    tick(1); chk("first_step", o_pos_y, 99);
    tick(24); chk("four_steps", o_pos_y, 96); chk("speed7", o_speed, 7);
    tick(100); chk("ramp_pos", o_pos_y, 76); chk("ramp_speed", o_speed, 2);
    tick(1); chk("min_int0", o_pos_y, 76);
    tick(1); chk("min_int1", o_pos_y, 75);
    tick(14); chk("min_hold", o_pos_y, 68); chk("min_speed", o_speed, 2);
    i_control_up = 1;
    tick(1); chk("release", o_moving, 0); chk("release_speed", o_speed, 8);
    // enable low freezes
    i_enable = 0; i_control_up = 0;
    tick(3); chk("dis_moving", o_moving, 0); chk("dis_pos", o_pos_y, 68);
    i_enable = 1;
    tick(1); chk("en_enter", o_moving, 1);
    tick(4); i_enable = 0;
    tick(1); chk("en_drop", o_moving, 0); chk("en_drop_speed", o_speed, 8);
    i_enable = 1;
    tick(1); chk("reenter", o_moving, 1);
    tick(84); chk("sp5_pos", o_pos_y, 56); chk("sp5", o_speed, 5);
    i_row = 60; i_col = 6; i_control_down = 0;
    tick(1); chk("both_idle", o_moving, 0); chk("both_speed", o_speed, 8);
    chk("both_pos", o_pos_y, 56); chk("both_rgb", o_rgb, 7);
    i_control_down = 1;
    tick(3);
    #3 i_rst_n = 0;
    #1 chk("async_pos", o_pos_y, 100); chk("async_rgb", o_rgb, 0);
    chk("async_moving", o_moving, 0); chk("async_speed", o_speed, 8);
    @(negedge i_clk);
    i_rst_n = 1; i_control_up = 1; i_row = 0; i_col = 0;
    // hold down to the bottom limit
    i_control_down = 0;
    for (int i = 0; i < 3000 && m_pos != 434; i++) tick(1);
    chk("reach434", o_pos_y, 434);
    i_control_down = 1;
    tick(1); chk("stop434", o_moving, 0);
    i_control_down = 0;
    tick(1); chk("dn_enter", o_moving, 1);
    tick(7); chk("dn_before", o_pos_y, 434);
    tick(1); chk("dn_step", o_pos_y, 435);
    tick(40); chk("pinned", o_pos_y, 435); chk("pinned_speed", o_speed, 8);
    chk("pinned_moving", o_moving, 1);
    i_control_down = 1;
    tick(1);
    // auto mode tracking
    i_rst_n = 0; tick(1); i_rst_n = 1;
    i_mode = 1; i_ball_y = 200;
    tick(1); chk("auto_dn", o_moving, 1);
    tick(7); chk("auto_dn_wait", o_pos_y, 100);
    tick(1); chk("auto_dn_step", o_pos_y, 101);
    i_ball_y = 118;
    tick(1); chk("auto_dead", o_moving, 0);
    tick(10); chk("auto_dead_pos", o_pos_y, 101); chk("auto_dead_mv", o_moving, 0);
    i_ball_y = 50;
    tick(1); chk("auto_up", o_moving, 1);
    tick(8); chk("auto_up_step", o_pos_y, 100);
    // draw
    i_mode = 0; i_ball_y = 0;
    i_rst_n = 0; tick(1); i_rst_n = 1;
    i_row = 100; i_col = 5; tick(1); chk("draw_tl", o_rgb, 7);
    i_row = 140; tick(1); chk("draw_below", o_rgb, 0);
    i_row = 120; i_col = 9; tick(1); chk("draw_right", o_rgb, 0);
    i_col = 8; tick(1); chk("draw_edge", o_rgb, 7);
    i_col = 4; tick(1); chk("draw_left", o_rgb, 0);
    i_row = 99; i_col = 5; tick(1); chk("draw_above", o_rgb, 0);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised second-generation Pong paddle. It supports two modes: joystick (human) and auto (CPU tracks ball_y). Held movement accelerates, and the paddle is clamped to playfield limits. It also provides a registered rectangle pixel output for the VGA compositor. One instance exists per player; the instances sit between joystick/ball logic and the pixel mux.

Parameters:
COLOR, 3'b111, rgb when pixel lies inside paddle
START_X, 5, reset/home x position
START_Y, 100, reset/home y position
WIDTH, 4, paddle width in pixels (<=255)
HEIGHT, 40, paddle height in pixels (<=255)
LIMIT_Y_MIN, 5, top limit; pos_y never below this
LIMIT_Y_MAX, 475, bottom limit; pos_y+HEIGHT never above this
DIV_START, 8, clocks per 1-pixel step when movement begins (2..255)
DIV_MIN, 2, fastest clocks per step (1..DIV_START)
ACCEL_STEPS, 4, steps taken at one divider before divider decrements
DEADBAND, 4, auto mode: tolerance in pixels around paddle centre

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = home position
enable  in  1  1 = movement allowed; 0 = freeze
mode  in  1  0 = joystick, 1 = auto
control_up  in  1  active-low joystick up
control_down  in  1  active-low joystick down
ball_y  in  10  ball top y, used in auto mode
row  in  10  pixel row queried
col  in  10  pixel column queried
rgb  out  3  registered pixel colour
pos_x  out  10  paddle left x (constant START_X)
pos_y  out  10  paddle top y
size_x  out  8  = WIDTH
size_y  out  8  = HEIGHT
speed  out  8  current divider (clocks per step)
moving  out  1  1 while in MOVE_UP/MOVE_DOWN

Behaviour:
- Reset (reset=0, async): state IDLE; pos_x=START_X; pos_y=START_Y; size_x=WIDTH; size_y=HEIGHT; speed=DIV_START; timer=0; step_cnt=0; rgb=0; moving=0.
- Direction request, recomputed each cycle:
  - Joystick mode: UP if control_up=0 and control_down=1; DOWN if control_down=0 and control_up=1. Both or neither low = NONE.
  - Auto mode: centre = pos_y + HEIGHT/2 (11-bit math). UP if ball_y + DEADBAND < centre; DOWN if ball_y > centre + DEADBAND; else NONE.
- FSM: IDLE, MOVE_UP, MOVE_DOWN.
  - IDLE: request UP -> MOVE_UP; request DOWN -> MOVE_DOWN. On entry to any state, timer=0, step_cnt=0, speed=DIV_START.
  - MOVE_x with the same request: timer++ each cycle. When timer==speed-1, timer=0 and a step is attempted.
  - MOVE_x with request NONE or the opposite direction: go to IDLE next cycle (no direct reversal) and reset the ramp.
- Step rules:
  - UP moves pos_y-1 only if pos_y > LIMIT_Y_MIN.
  - DOWN moves pos_y+1 only if pos_y+HEIGHT < LIMIT_Y_MAX (11-bit compare).
  - A blocked step does not increment step_cnt, so there is no acceleration while pinned at a limit.
  - A successful step increments step_cnt. When step_cnt reaches ACCEL_STEPS: step_cnt=0, and speed decrements if speed > DIV_MIN.
  - First step occurs DIV_START clocks after entering MOVE_x.
- enable=0: state forced to IDLE next cycle; pos_y held; ramp reset. Async reset overrides everything.
- moving = (state != IDLE), registered.
- Draw: rgb <= COLOR if pos_x <= col < pos_x+WIDTH and pos_y <= row < pos_y+HEIGHT, else 0. Latency is 1 clock. Uses the pos_y value registered at the sampling edge. Comparisons are 11-bit, with no wrap.
- A mode change mid-move is handled purely through the request rules above.

Test Plan:
1. Release reset with the joystick idle -> pos_y=100, speed=8, moving=0. Assert control_up=0 -> moving=1 next clock; first pos_y=99 exactly 8 clocks after entry.
2. Hold up for 4 steps -> pos_y=96 after 32 clocks, speed becomes 7. Continue holding -> speed reaches 2 and stays 2; the step interval measured = speed clocks.
3. Hold down from pos_y=434 (434+40=474) -> one step to 435, then blocked at 435. speed stays 8 and step_cnt does not advance; moving stays 1.
4. While moving up at speed 5, press both buttons -> IDLE next clock, speed=8. Pulse reset low mid-move -> pos_y=100 and rgb=0 immediately (async).
5. Auto mode, pos_y=100 (centre 120): ball_y=200 -> moves down; ball_y=118 -> NONE and no motion (within deadband); ball_y=50 -> moves up.
6. Draw at pos_y=100: row=100/col=5 -> rgb=7 one clock later; row=140/col=5 -> rgb=0; row=120/col=9 -> rgb=0; row=120/col=8 -> rgb=7.
